pixel_clip_stream: RTL and testbench
====================================

# pixel_clip_stream

Streaming, pipelined, multi-channel successor to the combinational pixel clipper. Takes CHANNELS signed fixed-point filter results per beat, rounds them per a runtime-selectable mode, and clamps them to unsigned OUT_W pixels. Adds a valid/ready handshake with backpressure, frame-end sideband, and optional clip statistics. Sits between the interpolation MAC array and the output pixel packer.

## Interface
- IN_W, 20: input sample width, two's complement
- FRAC_BITS, 7: fractional bits in input; legal range 1..IN_W-2
- OUT_W, 8: output pixel width, unsigned
- CHANNELS, 3: samples per beat (e.g. R,G,B)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- round_mode  in  2  0 truncate, 1 round-half-up, 2 round-half-to-even, 3 same as 1; sampled per accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CHANNELS*IN_W  channel c at [c*IN_W +: IN_W]
- in_last  in  1  last beat of frame, carried through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  CHANNELS*OUT_W  channel c at [c*OUT_W +: OUT_W]
- out_last  out  1  delayed in_last
- stats_clr  in  1  synchronous clear of clip counters
- clip_lo_cnt  out  32  count of channel samples clamped to 0
- clip_hi_cnt  out  32  count of channel samples clamped to max

## Operation
- Stage 1 (round), per channel: sign-extend x to IN_W+1 bits, add bias, arithmetic shift right FRAC_BITS. Extra bit guarantees no overflow (0x7FFFF + 64 must not wrap negative).
- Bias: mode 0 -> 0; modes 1/3 -> 2^(FRAC_BITS-1); mode 2 -> 2^(FRAC_BITS-1), except when fraction equals exactly half and the integer LSB is 0, where bias is 0.
- Stage 2 (clamp): rounded r < 0 -> 0; r > 2^OUT_W-1 -> 2^OUT_W-1; else r[OUT_W-1:0]. Negative test uses the sign of r, not of x (x = -0.25 in mode 1 rounds to 0, not clamped: counts as no clip).
- Pipeline control: s2_load = !out_valid || out_ready; s1_load = !s1_valid || s2_load; in_ready = s1_load (combinational from out_ready, documented path).
- Stage registers hold data, last and valid; a stalled stage holds all contents stable.
- in_last has no effect on datapath; only propagated.
- Stats: on each output handshake, clip_lo_cnt += number of channels clamped low in that beat, clip_hi_cnt likewise; counters saturate at 0xFFFFFFFF. stats_clr wins over same-cycle increment.

## Timing
- Reset: out_valid=0, out_data=0, out_last=0, internal valids=0, counters=0; in_ready=1 one cycle after reset release (combinationally 1 while stages empty).
- Latency: accepted beat appears on out_valid 2 cycles later with out_ready high; throughput 1 beat/cycle.
- Backpressure: with out_ready low, pipeline absorbs up to 2 beats, then in_ready=0. out_data/out_last stable while out_valid && !out_ready.
- Simultaneous out handshake and full stages: both stages advance same cycle, no bubble.
- round_mode change mid-stream affects only beats accepted after the change.
- Reset mid-operation: in-flight beats discarded, no partial output.

## Configuration
- CLIP_STATS_EN defined: counters and stats_clr logic implemented as above.
- Not defined: clip_lo_cnt and clip_hi_cnt tied to 0, stats_clr ignored; ports remain for uniform integration.

## Test plan
- Defaults, mode 1, out_ready=1: channels {64, 191, 32767} -> {1, 1, 255} 2 cycles after accept; mode 0 same input -> {0, 1, 255}.
- Mode 2: {192, 320, 448} -> {2, 2, 4}; mode 1 same input -> {2, 3, 4}.
- Boundaries: {0xFFF80 (-1.0), 0xFFFE0 (-0.25), 0x7FFFF} in mode 1 -> {0, 0, 255}; CLIP_STATS_EN counters lo=1, hi=1.
- Backpressure: stream 6 beats 1..6 with out_ready low cycles 2-6 -> in_ready low after 2 beats held, all 6 beats out in order, no duplicates, in_last on beat 6 only.
- Reset asserted with 2 beats in flight -> out_valid=0 immediately, counters 0, next accepted beat emerges 2 cycles after accept.
- Stats: 3 beats each clamping all channels high, stats_clr pulsed same cycle as 3rd handshake -> clip_hi_cnt=0 next cycle; without CLIP_STATS_EN both counters read 0 throughout.

Source files
------------

// File: rtl/pixel_clip_stream.sv
// Two-stage round/clamp pipeline for CHANNELS signed fixed-point samples, valid/ready handshake.
// Define CLIP_STATS_EN to build the saturating clip counters; otherwise they read 0.
module pixel_clip_stream #(
  parameter int unsigned IN_W      = 20,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned CHANNELS  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                round_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      out_last,
  input  logic                      stats_clr,
  output logic [31:0]               clip_lo_cnt,
  output logic [31:0]               clip_hi_cnt
);

  localparam int unsigned RW = IN_W + 1 - FRAC_BITS;
  localparam logic [IN_W:0]   Half   = (IN_W + 1)'(1) << (FRAC_BITS - 1);
  localparam logic [RW-1:0]   MaxPix = {{(RW - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic                      w_s1_load;
  logic                      w_s2_load;
  logic [IN_W-1:0]           w_x    [CHANNELS];
  logic signed [IN_W:0]      w_bias [CHANNELS];
  logic signed [IN_W:0]      w_sum  [CHANNELS];
  logic [RW-1:0]             w_rnd  [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] w_pix;
  logic [CHANNELS-1:0]       w_lo;
  logic [CHANNELS-1:0]       w_hi;

  logic                      r_s1_valid;
  logic                      r_s1_last;
  logic [RW-1:0]             r_s1_rnd [CHANNELS];
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [CHANNELS*OUT_W-1:0] r_out_data;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  // Stage 1: one guard bit above the sample so adding the bias can never wrap.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_x[c] = in_data[c*IN_W +: IN_W];
      case (round_mode)
        2'd0:    w_bias[c] = '0;
        2'd2:    w_bias[c] = (w_x[c][FRAC_BITS-1:0] == Half[FRAC_BITS-1:0] && !w_x[c][FRAC_BITS])
                             ? '0 : Half;
        default: w_bias[c] = Half;
      endcase
      w_sum[c] = $signed({w_x[c][IN_W-1], w_x[c]}) + w_bias[c];
      w_rnd[c] = RW'(w_sum[c] >>> FRAC_BITS);
    end
  end

  // Stage 2: clamp decision uses the sign of the rounded value, not of the raw sample.
  always_comb begin
    w_pix = '0;
    w_lo  = '0;
    w_hi  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_lo[c] = r_s1_rnd[c][RW-1];
      w_hi[c] = !w_lo[c] && (r_s1_rnd[c] > MaxPix);
      if (w_lo[c]) begin
        w_pix[c*OUT_W +: OUT_W] = '0;
      end else if (w_hi[c]) begin
        w_pix[c*OUT_W +: OUT_W] = MaxPix[OUT_W-1:0];
      end else begin
        w_pix[c*OUT_W +: OUT_W] = r_s1_rnd[c][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_s1_rnd[c] <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_last <= in_last;
        for (int c = 0; c < CHANNELS; c++) r_s1_rnd[c] <= w_rnd[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_last <= r_s1_last;
        r_out_data <= w_pix;
      end
    end
  end

`ifdef CLIP_STATS_EN
  logic [CHANNELS-1:0] r_out_lo;
  logic [CHANNELS-1:0] r_out_hi;
  logic [31:0]         r_lo_cnt;
  logic [31:0]         r_hi_cnt;

  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [CHANNELS-1:0] flags);
    logic [32:0] sum;
    sum = {1'b0, cnt};
    for (int c = 0; c < CHANNELS; c++) sum = sum + 33'(flags[c]);
    return sum[32] ? '1 : sum[31:0];
  endfunction

  // Clip flags travel with the output beat and are counted only when it is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_lo <= '0;
      r_out_hi <= '0;
      r_lo_cnt <= '0;
      r_hi_cnt <= '0;
    end else begin
      if (w_s2_load && r_s1_valid) begin
        r_out_lo <= w_lo;
        r_out_hi <= w_hi;
      end
      if (stats_clr) begin
        r_lo_cnt <= '0;
        r_hi_cnt <= '0;
      end else if (r_out_valid && out_ready) begin
        r_lo_cnt <= sat_add(r_lo_cnt, r_out_lo);
        r_hi_cnt <= sat_add(r_hi_cnt, r_out_hi);
      end
    end
  end

  assign clip_lo_cnt = r_lo_cnt;
  assign clip_hi_cnt = r_hi_cnt;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign clip_lo_cnt        = '0;
  assign clip_hi_cnt        = '0;
`endif

endmodule

// File: tb/tb_pixel_clip_stream.sv
// Self-checking bench for pixel_clip_stream: directed vectors plus randomized streams
// checked against an arithmetic rounding/clamping model.
`timescale 1ns/1ps
module tb_pixel_clip_stream;

  localparam int IN_W = 20;
  localparam int FRAC = 7;
  localparam int OUT_W = 8;
  localparam int CH = 3;
`ifdef CLIP_STATS_EN
  localparam int StatsEn = 1;
`else
  localparam int StatsEn = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             round_mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*IN_W-1:0]     in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*OUT_W-1:0]    out_data;
  logic                   out_last;
  logic                   stats_clr;
  logic [31:0]            clip_lo_cnt;
  logic [31:0]            clip_hi_cnt;

  int errors = 0;
  int checks = 0;

  logic [CH*IN_W-1:0]  q_in_data[$];
  logic                q_in_last[$];
  logic [1:0]          q_mode[$];
  logic [CH*OUT_W-1:0] got_data[$];
  logic                got_last[$];
  int stall_err;
  int stall_cyc;
  int nready_cyc;

  pixel_clip_stream #(.IN_W(IN_W), .FRAC_BITS(FRAC), .OUT_W(OUT_W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .round_mode(round_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .stats_clr(stats_clr),
    .clip_lo_cnt(clip_lo_cnt), .clip_hi_cnt(clip_hi_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint round_ch(input logic [IN_W-1:0] raw, input logic [1:0] m);
    longint x, one, fl, fr;
    x   = longint'($signed(raw));
    one = longint'(1) << FRAC;
    fl  = floor_div(x, one);
    fr  = x - fl * one;
    if (m == 2'd0) return fl;
    if (m == 2'd2 && 2 * fr == one) return (fl % 2 == 0) ? fl : fl + 1;
    return (2 * fr >= one) ? fl + 1 : fl;
  endfunction

  function automatic logic [CH*OUT_W-1:0] model_beat(input logic [CH*IN_W-1:0] d,
                                                     input logic [1:0] m,
                                                     output int lo, output int hi);
    logic [CH*OUT_W-1:0] res;
    longint r;
    longint maxv;
    maxv = (longint'(1) << OUT_W) - 1;
    res = '0;
    lo = 0;
    hi = 0;
    for (int c = 0; c < CH; c++) begin
      r = round_ch(d[c*IN_W +: IN_W], m);
      if (r < 0) lo++;
      else if (r > maxv) begin
        hi++;
        res[c*OUT_W +: OUT_W] = OUT_W'(maxv);
      end else res[c*OUT_W +: OUT_W] = OUT_W'(r);
    end
    return res;
  endfunction

  function automatic logic [CH*IN_W-1:0] pack3(input int a0, input int a1, input int a2);
    logic [IN_W-1:0] c0, c1, c2;
    c0 = IN_W'(a0);
    c1 = IN_W'(a1);
    c2 = IN_W'(a2);
    return {c2, c1, c0};
  endfunction

  function automatic logic [IN_W-1:0] rand_sample();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return IN_W'($urandom);
      1:       return IN_W'(int'($urandom_range(0, 40000)) - 4000);
      2:       return IN_W'((int'($urandom_range(0, 300)) - 20) * 128 + 64);
      default: return IN_W'(int'($urandom_range(0, 255)) * 128 + int'($urandom_range(0, 127)));
    endcase
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic q_clear();
    q_in_data.delete();
    q_in_last.delete();
    q_mode.delete();
  endtask

  task automatic q_push(input logic [CH*IN_W-1:0] d, input logic l, input logic [1:0] m);
    q_in_data.push_back(d);
    q_in_last.push_back(l);
    q_mode.push_back(m);
  endtask

  task automatic pulse_clr();
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low in cycles 2..6. vmode 1 = random gaps.
  task automatic run_stream(input int rmode, input int vmode);
    int idx;
    int n;
    int cyc;
    logic acc;
    logic prev_stall;
    logic [CH*OUT_W-1:0] prev_d;
    logic prev_l;
    idx = 0;
    n = q_in_data.size();
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    got_data.delete();
    got_last.delete();
    stall_err = 0;
    stall_cyc = 0;
    nready_cyc = 0;
    while (got_data.size() < n && cyc < 1000) begin
      in_valid = (idx < n) && (vmode == 0 || $urandom_range(0, 2) != 0);
      if (idx < n) begin
        in_data = q_in_data[idx];
        in_last = q_in_last[idx];
        round_mode = q_mode[idx];
      end else begin
        in_data = pack3($urandom, $urandom, $urandom);
        in_last = 1'b0;
      end
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(cyc >= 2 && cyc <= 6);
      @(negedge clk);
      if (prev_stall && (out_data !== prev_d || out_last !== prev_l)) stall_err++;
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cyc++;
      if (in_valid && !in_ready) nready_cyc++;
      prev_d = out_data;
      prev_l = out_last;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    round_mode = 2'd0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (clip_lo_cnt !== 32'd0 || clip_hi_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got lo=%0d hi=%0d want 0/0", clip_lo_cnt, clip_hi_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    in_data = pack3(64, 191, 32767); round_mode = 2'd1; in_last = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1 got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'hFF0101) begin
      errors++; $display("FAIL lat_cycle2 got v=%b d=%h want v=1 d=ff0101", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_no_dup got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [CH*OUT_W-1:0] exp_d [4];
    q_clear();
    q_push(pack3(64, 191, 32767), 1'b0, 2'd0); exp_d[0] = 24'hFF0100;
    q_push(pack3(192, 320, 448), 1'b0, 2'd2);  exp_d[1] = 24'h040202;
    q_push(pack3(192, 320, 448), 1'b0, 2'd1);  exp_d[2] = 24'h040302;
    q_push(pack3(192, 320, 448), 1'b1, 2'd3);  exp_d[3] = 24'h040302;
    run_stream(0, 0);
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL vec_count got %0d want 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL vec_beat%0d got d=%h l=%b want d=%h l=%b", i, got_data[i], got_last[i], exp_d[i], i == 3);
      end
    end
  endtask

  task automatic test_boundary();
    pulse_clr();
    q_clear();
    q_push(pack3('hFFF80, 'hFFFE0, 'h7FFFF), 1'b1, 2'd1);
    run_stream(0, 0);
    checks++; if (got_data.size() != 1 || got_data[0] !== 24'hFF0000) begin
      errors++; $display("FAIL bound_data got n=%0d d=%h want n=1 d=ff0000", got_data.size(), got_data.size() ? got_data[0] : '0);
    end
    checks++; if (clip_lo_cnt !== 32'(StatsEn) || clip_hi_cnt !== 32'(StatsEn)) begin
      errors++; $display("FAIL bound_stats got lo=%0d hi=%0d want %0d/%0d", clip_lo_cnt, clip_hi_cnt, StatsEn, StatsEn);
    end
  endtask

  task automatic test_backpressure();
    logic [CH*OUT_W-1:0] e;
    q_clear();
    for (int v = 1; v <= 6; v++) q_push(pack3(v * 128, (v + 10) * 128, (v + 20) * 128 + 100), v == 6, 2'd0);
    run_stream(2, 0);
    checks++; if (got_data.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got_data.size()); end
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      e = {8'(i + 21), 8'(i + 11), 8'(i + 1)};
      checks++; if (got_data[i] !== e || got_last[i] !== (i == 5)) begin
        errors++; $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b", i, got_data[i], got_last[i], e, i == 5);
      end
    end
    checks++; if (nready_cyc != 5) begin errors++; $display("FAIL bp_in_ready_low got %0d cycles want 5", nready_cyc); end
    checks++; if (stall_cyc != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", stall_cyc); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes want 0", stall_err); end
  endtask

  task automatic test_reset_midstream();
    round_mode = 2'd1; in_last = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_data = pack3(128, 256, 384);
    @(posedge clk); #1;
    in_data = pack3(512, 640, 768);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_inflight got out_valid=%b want 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL rstm_flush got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    checks++; if (clip_lo_cnt !== 32'd0 || clip_hi_cnt !== 32'd0) begin
      errors++; $display("FAIL rstm_counters got lo=%0d hi=%0d want 0/0", clip_lo_cnt, clip_hi_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_no_partial got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = pack3(300, 0, 2000);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_accept got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_lat1 got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'h100002) begin
      errors++; $display("FAIL rstm_lat2 got v=%b d=%h want v=1 d=100002", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stats();
    pulse_clr();
    @(negedge clk);
    checks++; if (clip_lo_cnt !== 32'd0 || clip_hi_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_clear got lo=%0d hi=%0d want 0/0", clip_lo_cnt, clip_hi_cnt);
    end
    @(posedge clk); #1;
    round_mode = 2'd1; out_ready = 1'b1; in_last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      in_data = pack3('h7FFFF, 'h40000, 'h7FF00);
      stats_clr = (k == 4);
      @(negedge clk);
      if (k == 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 24'hFFFFFF) begin
          errors++; $display("FAIL stats_beat got v=%b d=%h want v=1 d=ffffff", out_valid, out_data);
        end
      end
      if (k == 3) begin
        checks++; if (clip_hi_cnt !== 32'(3 * StatsEn)) begin
          errors++; $display("FAIL stats_hi_after1 got %0d want %0d", clip_hi_cnt, 3 * StatsEn);
        end
      end
      if (k == 4) begin
        checks++; if (clip_hi_cnt !== 32'(6 * StatsEn)) begin
          errors++; $display("FAIL stats_hi_after2 got %0d want %0d", clip_hi_cnt, 6 * StatsEn);
        end
      end
      if (k == 5) begin
        checks++; if (clip_hi_cnt !== 32'd0 || clip_lo_cnt !== 32'd0) begin
          errors++; $display("FAIL stats_clr_wins got lo=%0d hi=%0d want 0/0", clip_lo_cnt, clip_hi_cnt);
        end
      end
      @(posedge clk); #1;
    end
    stats_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    int lo, hi, tot_lo, tot_hi, n;
    logic [CH*OUT_W-1:0] e;
    q_clear();
    n = 60;
    for (int i = 0; i < n; i++) begin
      q_push({rand_sample(), rand_sample(), rand_sample()}, 1'($urandom_range(0, 7) == 0),
             2'($urandom_range(0, 3)));
    end
    run_stream(1, 1);
    checks++; if (got_data.size() != n) begin errors++; $display("FAIL rand_count got %0d want %0d", got_data.size(), n); end
    tot_lo = 0;
    tot_hi = 0;
    for (int i = 0; i < n; i++) begin
      e = model_beat(q_in_data[i], q_mode[i], lo, hi);
      tot_lo += lo;
      tot_hi += hi;
      if (i < got_data.size()) begin
        checks++; if (got_data[i] !== e || got_last[i] !== q_in_last[i]) begin
          errors++; $display("FAIL rand_beat%0d in=%h mode=%0d got d=%h l=%b want d=%h l=%b", i,
                             q_in_data[i], q_mode[i], got_data[i], got_last[i], e, q_in_last[i]);
        end
      end
    end
    checks++; if (clip_lo_cnt !== 32'(tot_lo * StatsEn) || clip_hi_cnt !== 32'(tot_hi * StatsEn)) begin
      errors++; $display("FAIL rand_stats got lo=%0d hi=%0d want %0d/%0d", clip_lo_cnt, clip_hi_cnt,
                         tot_lo * StatsEn, tot_hi * StatsEn);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_boundary();
    test_backpressure();
    test_reset_midstream();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
